code_serializer: RTL and testbench

CODE_SERIALIZER -- requirements
Module: code_serializer

---
 rtl/code_serializer.sv | 177 +++++++++++++++++
 tb/tb_code_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/code_serializer.sv
// Purpose: buffers 8-bit code words in a small FIFO and sends each one as a serial
//   frame (start, 8 data bits LSB first, optional even parity, stop) on an idle-high line.
// Latency: a push into an empty buffer at edge N drives the start bit from edge N+1.
//   Frames are (10+PARITY_EN)*CLKS_PER_BIT cycles long and run back to back with no gap.
// Backpressure: in_ready drops while the buffer holds FIFO_DEPTH words; it also stays
//   low in reset and rises on the first edge after rst_l deasserts.
// Ports: clk, rst_l (async, active-low); in_data/in_valid/in_ready upstream handshake;
//   tx serial line (registered); busy (frame in progress); frame_done (last stop cycle);
//   level (words buffered).
module code_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int FIFO_DEPTH   = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          tx,
  output logic          busy,
  output logic          frame_done,
  output logic [LW-1:0] level
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Word buffer
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_rdy_en;

  // Frame engine
  state_t        r_state;
  logic [7:0]    r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;

  logic          w_push;
  logic          w_pop;
  logic          w_last;
  logic [7:0]    w_head;

  assign w_last   = (r_cnt == 8'(CLKS_PER_BIT - 1));
  assign w_head   = r_mem[r_rd_ptr];
  assign in_ready = r_rdy_en && (r_level != LW'(FIFO_DEPTH));
  assign w_push   = in_valid && in_ready;
  // Pop only when the engine is ready to start a frame: from IDLE, or on the last
  // stop cycle so the next start bit follows without a gap.
  assign w_pop    = (r_level != '0) &&
                    ((r_state == IDLE) || ((r_state == STOP) && w_last));

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign level      = r_level;

  // in_ready is held low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Outputs are registered alongside the state so tx/busy/frame_done change on the
  // same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= r_cnt + 8'd1;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= ^w_head;
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_state <= PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
        end
        STOP: begin
          // Raise frame_done so it is high exactly during the last stop cycle.
          if (r_cnt == 8'(CLKS_PER_BIT - 2)) r_done <= 1'b1;
          if (w_last) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_par   <= ^w_head;
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_serializer.sv
// Bench for code_serializer: scoreboard queue of pushed words checked cycle by cycle
// against the serial line, plus directed checks of reset, backpressure and a
// parity-less instance.
module tb_code_serializer;

  localparam int CPB = 4;
  localparam int FL  = 11 * CPB;

  logic       clk;
  logic       rst_l;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] level;

  logic [7:0] in_data0;
  logic       in_valid0;
  logic       in_ready0;
  logic       tx0;
  logic       busy0;
  logic       frame_done0;
  logic [2:0] level0;

  code_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_l(rst_l), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done), .level(level)
  );

  code_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_l(rst_l), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .tx(tx0), .busy(busy0), .frame_done(frame_done0), .level(level0)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  int         start_log[$];
  int         done_log[$];

  bit         in_frame = 1'b0;
  int         mon_idx  = 0;
  logic [10:0] fbits;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial-line monitor: each frame start pops the next expected word and every
  // cycle of the frame is compared against the frame built from that word.
  always @(negedge clk) begin
    if (!rst_l) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL unexpected_frame observed=start_bit expected=idle cyc=%0d", cyc);
        end else begin
          logic [7:0] w;
          w = exp_q.pop_front();
          fbits = {1'b1, ^w, w, 1'b0};
          in_frame = 1'b1;
          mon_idx = 0;
          start_log.push_back(cyc);
        end
      end
      if (in_frame) begin
        check("tx_bit", 32'(tx), 32'(fbits[mon_idx / CPB]));
        check("busy_in_frame", 32'(busy), 32'(1));
        check("frame_done", 32'(frame_done), 32'(mon_idx == FL - 1));
        if (frame_done === 1'b1) done_log.push_back(cyc);
        mon_idx++;
        if (mon_idx == FL) in_frame = 1'b0;
      end
    end
  end

  // Called at a negedge; holds in_valid until the word is accepted, leaves it high.
  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait_bound", 32'(t < 500), 32'(1));
    exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_frame || busy === 1'b1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain_bound", 32'(t < 5000), 32'(1));
  endtask

  initial begin
    int pe;
    int t;
    rst_l     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid0 = 1'b0;
    in_data0  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(frame_done), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(0));
    check("rst_tx0", 32'(tx0), 32'(1));
    #1 rst_l = 1'b1;
    #1 check("ready_before_edge", 32'(in_ready), 32'(0));
    @(negedge clk);
    check("ready_after_edge", 32'(in_ready), 32'(1));

    // Single frame 0xA5 into an empty buffer
    pe = cyc + 1;
    send(8'hA5);
    in_valid = 1'b0;
    check("lvl_after_push", 32'(level), 32'(1));
    @(negedge clk);
    check("lvl_after_pop", 32'(level), 32'(0));
    wait_drain();
    check("a5_start_latency", 32'(start_log[$] - pe), 32'(1));
    check("a5_done_offset", 32'(done_log[$] - start_log[$]), 32'(FL - 1));
    check("a5_idle_tx", 32'(tx), 32'(1));
    check("a5_idle_busy", 32'(busy), 32'(0));

    // Two back-to-back frames
    pe = cyc + 1;
    send(8'h01);
    send(8'h02);
    in_valid = 1'b0;
    wait_drain();
    check("b2b_start_latency", 32'(start_log[$-1] - pe), 32'(1));
    check("b2b_start_gap", 32'(start_log[$] - start_log[$-1]), 32'(FL));
    check("b2b_done_gap", 32'(done_log[$] - done_log[$-1]), 32'(FL));

    // Streaming six words with in_valid held: buffer fills, word order preserved
    send(8'h11);
    check("fill_lvl0", 32'(level), 32'(1));
    send(8'h22);
    check("fill_lvl1_pushpop", 32'(level), 32'(1));
    send(8'h33);
    check("fill_lvl2", 32'(level), 32'(2));
    send(8'h44);
    check("fill_lvl3", 32'(level), 32'(3));
    send(8'h55);
    check("fill_lvl4", 32'(level), 32'(4));
    check("full_ready", 32'(in_ready), 32'(0));
    send(8'h66);
    check("refill_lvl", 32'(level), 32'(4));
    in_valid = 1'b0;
    wait_drain();

    // Reset during data bit 3 with two words queued
    send(8'h5A);
    send(8'hC3);
    send(8'h96);
    in_valid = 1'b0;
    check("pre_rst_lvl", 32'(level), 32'(2));
    t = 0;
    while ((!in_frame || mon_idx < 18) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("bit3_wait_bound", 32'(t < 500), 32'(1));
    #1 rst_l = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_tx", 32'(tx), 32'(1));
    check("midrst_level", 32'(level), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    check("midrst_hold_tx", 32'(tx), 32'(1));
    #1 rst_l = 1'b1;
    @(negedge clk);
    send(8'h3C);
    in_valid = 1'b0;
    wait_drain();
    check("post_rst_busy", 32'(busy), 32'(0));

    // Parity-less instance: 0xFF gives a 40-cycle frame
    @(negedge clk);
    check("np_ready", 32'(in_ready0), 32'(1));
    in_valid0 = 1'b1;
    in_data0  = 8'hFF;
    @(negedge clk);
    in_valid0 = 1'b0;
    check("np_lvl", 32'(level0), 32'(1));
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      check("np_tx", 32'(tx0), 32'(i >= CPB));
      check("np_busy", 32'(busy0), 32'(1));
      check("np_done", 32'(frame_done0), 32'(i == 10 * CPB - 1));
    end
    @(negedge clk);
    check("np_end_busy", 32'(busy0), 32'(0));
    check("np_end_tx", 32'(tx0), 32'(1));
    check("np_end_done", 32'(frame_done0), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
